akum_stos: RTL and testbench
============================

Name: akum_stos

Overview:
- LIFO stack that saves and restores the accumulator. It reads the accumulator value on push and returns the stored value on pop, for loading back into the accumulator.
- Used by the control unit for PUSH A, POP A and XCHG (swap) instructions, and for saving the accumulator on subroutine entry.
- Sits between the accumulator output and the accumulator input mux. It is single-clock with registered outputs.

Parameters:
- ALU_rozm_data, 8, data width in bits; matches the accumulator width.
- GLEBOKOSC, 8, number of stack entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high. Clears all state immediately.
- din  input  ALU_rozm_data  value to push; driven by the accumulator output.
- push  input  1  push request, sampled on the rising clk edge.
- pop  input  1  pop request, sampled on the rising clk edge.
- err_clr  input  1  clears the sticky error flags.
- dout  output  ALU_rozm_data  registered popped value; goes to the accumulator input mux.
- dout_valid  output  1  single-cycle pulse; dout holds newly popped data this cycle.
- pusty  output  1  stack empty (licznik == 0).
- pelny  output  1  stack full (licznik == GLEBOKOSC).
- licznik  output  $clog2(GLEBOKOSC)+1  current number of entries.
- przepelnienie  output  1  sticky overflow flag: push attempted while full.
- niedomiar  output  1  sticky underflow flag: pop attempted while empty.

Behaviour:
Reset (asynchronous, any time, including mid-operation):
- licznik=0, dout=0, dout_valid=0, przepelnienie=0, niedomiar=0.
- Memory contents are not reset. Their values are don't-care and must never reach dout after reset.

Outputs:
- pusty and pelny are decoded combinationally from the licznik register. They carry no extra latency.

Operation, decoded each cycle from {push,pop}:
- NOP (0,0): no state change; dout holds; dout_valid=0.
- PUSH (1,0), not full: mem[licznik] <= din; licznik++.
- PUSH (1,0), full: no write; licznik unchanged; przepelnienie <= 1.
- POP (0,1), not empty: dout <= mem[licznik-1]; licznik--; dout_valid=1 in the next cycle.
- POP (0,1), empty: dout holds; dout_valid=0; niedomiar <= 1.
- SWAP (1,1), not empty: dout <= old mem[licznik-1], and mem[licznik-1] <= din in the same edge; licznik unchanged; dout_valid=1. Full counts as not empty, so SWAP never flags overflow.
- SWAP (1,1), empty: bypass: dout <= din; dout_valid=1; licznik stays 0; no error flag.

Latency and hazards:
- Pop latency is 1 cycle: request at edge N, data on dout with dout_valid after edge N.
- Back-to-back pushes and pops are allowed every cycle at full throughput.
- No read-during-write hazard exists. PUSH writes at index licznik, while POP and SWAP read at licznik-1 before the edge.

Sticky flags:
- err_clr clears both flags at the next edge.
- If err_clr and a new error occur in the same cycle, the flag is set (error wins).
- Flags never affect normal operation.

Wrap-around and width:
- licznik saturates at 0 and at GLEBOKOSC; no pointer wrap is allowed.
- Internal address is licznik[$clog2(GLEBOKOSC)-1:0]. Data passes through unchanged, with no arithmetic on data.

Decomposition:
- Package akum_stos_pkg:
  - typedef enum logic [1:0] {OP_NOP, OP_PUSH, OP_POP, OP_SWAP} stos_op_t, encoded as {push,pop}.
  - Function for the licznik width.
- Sub-module stos_pamiec:
  - GLEBOKOSC x ALU_rozm_data register file.
  - One synchronous write port and one asynchronous read port.
  - No reset.
- akum_stos holds the op decode, licznik, dout register and error flags.

Test Plan (GLEBOKOSC=4, ALU_rozm_data=8):
1. Push 0x11, 0x22, 0x33, then pop x3 on consecutive cycles -> dout 0x33, 0x22, 0x11, each with dout_valid one cycle after the request. licznik counts 3->0; pusty=1 at the end.
2. Push 0xA0..0xA3 (full, pelny=1), then push 0xFF -> przepelnienie=1 and licznik stays 4. Pop -> 0xA3, proving 0xFF was not written. Then err_clr -> przepelnienie=0.
3. Pop on empty -> niedomiar=1, dout_valid=0, dout unchanged. Assert err_clr and pop-on-empty in the same cycle -> niedomiar stays 1.
4. Push 0x55, then SWAP with din=0x66 -> dout=0x55, dout_valid=1, licznik=1. Pop -> 0x66. Then SWAP on empty with din=0x77 -> dout=0x77, licznik=0, no flags.
5. Push 0x01, 0x02, then assert rst mid-cycle (asynchronously, between clock edges) -> licznik, dout, dout_valid and flags go to 0 immediately, before the next edge. After release, pop -> niedomiar=1 and no stale data.
6. Random push/pop/swap for 1000 cycles against a queue reference model, checking dout, dout_valid, licznik, pusty, pelny and the flags every cycle.

Source files
------------

// File: rtl/akum_stos_pkg.sv
// Shared types and helpers for the accumulator save/restore stack.
package akum_stos_pkg;

    // Encoded directly as {push, pop} so the decode is a plain cast.
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b10,
        OP_POP  = 2'b01,
        OP_SWAP = 2'b11
    } stos_op_t;

    // Counter must hold 0..glebokosc inclusive.
    function automatic int licznik_w(input int glebokosc);
        return $clog2(glebokosc) + 1;
    endfunction

endpackage

// File: rtl/stos_pamiec.sv
// Stack storage: synchronous write, asynchronous read, no reset.
module stos_pamiec #(
    parameter int SZER = 8,
    parameter int GLEB = 8
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [$clog2(GLEB)-1:0] wr_addr,
    input  logic [SZER-1:0]         wr_data,
    input  logic [$clog2(GLEB)-1:0] rd_addr,
    output logic [SZER-1:0]         rd_data
);

    logic [SZER-1:0] mem [GLEB];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/akum_stos.sv
// LIFO stack saving/restoring the accumulator: op decode, entry counter,
// registered pop output and sticky overflow/underflow flags.
module akum_stos
    import akum_stos_pkg::*;
#(
    parameter int ALU_rozm_data = 8,
    parameter int GLEBOKOSC     = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ALU_rozm_data-1:0]           din,
    input  logic                               push,
    input  logic                               pop,
    input  logic                               err_clr,
    output logic [ALU_rozm_data-1:0]           dout,
    output logic                               dout_valid,
    output logic                               pusty,
    output logic                               pelny,
    output logic [licznik_w(GLEBOKOSC)-1:0]    licznik,
    output logic                               przepelnienie,
    output logic                               niedomiar
);

    localparam int AW = $clog2(GLEBOKOSC);
    localparam int CW = licznik_w(GLEBOKOSC);

    stos_op_t                 op;
    logic [AW-1:0]            ptr;
    logic [AW-1:0]            top_addr;
    logic [AW-1:0]            wr_addr;
    logic                     wr_en;
    logic [ALU_rozm_data-1:0] rd_data;

    assign op       = stos_op_t'({push, pop});
    assign pusty    = (licznik == '0);
    assign pelny    = (licznik == CW'(GLEBOKOSC));
    assign ptr      = licznik[AW-1:0];
    // When full the low bits wrap to 0, so ptr-1 still lands on the top entry.
    assign top_addr = ptr - AW'(1);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ptr;
        unique case (op)
            OP_PUSH: wr_en = !pelny;
            OP_SWAP: begin
                wr_en   = !pusty;
                wr_addr = top_addr;
            end
            default: ;
        endcase
    end

    stos_pamiec #(
        .SZER (ALU_rozm_data),
        .GLEB (GLEBOKOSC)
    ) u_pamiec (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (din),
        .rd_addr (top_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            licznik       <= '0;
            dout          <= '0;
            dout_valid    <= 1'b0;
            przepelnienie <= 1'b0;
            niedomiar     <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            // Clear first so a same-cycle error below takes precedence.
            if (err_clr) begin
                przepelnienie <= 1'b0;
                niedomiar     <= 1'b0;
            end
            unique case (op)
                OP_PUSH: begin
                    if (pelny) przepelnienie <= 1'b1;
                    else       licznik       <= licznik + CW'(1);
                end
                OP_POP: begin
                    if (pusty) begin
                        niedomiar <= 1'b1;
                    end else begin
                        dout       <= rd_data;
                        dout_valid <= 1'b1;
                        licznik    <= licznik - CW'(1);
                    end
                end
                OP_SWAP: begin
                    // Empty swap bypasses the accumulator value straight back.
                    dout       <= pusty ? din : rd_data;
                    dout_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_akum_stos.sv
// Scoreboard bench for akum_stos: directed scenarios plus random traffic
// against a queue reference model.
module tb_akum_stos;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk, rst, push, pop, err_clr;
    logic [W-1:0]  din, dout;
    logic          dout_valid, pusty, pelny, przepelnienie, niedomiar;
    logic [CW-1:0] licznik;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q [$];
    logic [W-1:0] stk [$];
    logic [W-1:0] m_dout;
    logic         m_vld, m_ovf, m_unf;

    akum_stos #(.ALU_rozm_data(W), .GLEBOKOSC(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .din           (din),
        .push          (push),
        .pop           (pop),
        .err_clr       (err_clr),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .pusty         (pusty),
        .pelny         (pelny),
        .licznik       (licznik),
        .przepelnienie (przepelnienie),
        .niedomiar     (niedomiar)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " licznik"}, 32'(licznik), 32'(stk.size()));
        chk({tag, " pusty"}, 32'(pusty), 32'(stk.size() == 0));
        chk({tag, " pelny"}, 32'(pelny), 32'(stk.size() == D));
        chk({tag, " przepelnienie"}, 32'(przepelnienie), 32'(m_ovf));
        chk({tag, " niedomiar"}, 32'(niedomiar), 32'(m_unf));
        chk({tag, " dout"}, 32'(dout), 32'(m_dout));
        chk({tag, " dout_valid"}, 32'(dout_valid), 32'(m_vld));
    endtask

    task automatic model_reset();
        stk.delete();
        m_dout = '0;
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Called just after a rising edge; applies one op across the next edge.
    task automatic step(input string tag, input logic p, input logic q,
                        input logic c, input logic [W-1:0] d);
        push = p; pop = q; err_clr = c; din = d;
        m_vld = 1'b0;
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (p && !q) begin
            if (stk.size() < D) stk.push_back(d);
            else                m_ovf = 1'b1;
        end else if (!p && q) begin
            if (stk.size() > 0) begin
                m_dout = stk.pop_back();
                m_vld  = 1'b1;
            end else begin
                m_unf = 1'b1;
            end
        end else if (p && q) begin
            if (stk.size() > 0) begin
                m_dout = stk[stk.size()-1];
                stk[stk.size()-1] = d;
            end else begin
                m_dout = d;
            end
            m_vld = 1'b1;
        end
        if (m_vld) exp_q.push_back(m_dout);
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        check_state(tag);
    endtask

    // Monitor: every dout_valid pulse must match the oldest expected value.
    always @(negedge clk) begin
        if (!rst && dout_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got dout_valid with dout=%0h, required no pulse", dout);
            end else begin
                chk("sb_dout", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int r;
        rst = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; din = '0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_state("reset");
        @(negedge clk) rst = 1'b0;

        // 1: basic LIFO order
        step("t1 push", 1, 0, 0, 8'h11);
        step("t1 push", 1, 0, 0, 8'h22);
        step("t1 push", 1, 0, 0, 8'h33);
        chk("t1 cnt3", 32'(licznik), 32'd3);
        step("t1 pop", 0, 1, 0, 8'h00);
        chk("t1 pop1", 32'(dout), 32'h33);
        step("t1 pop", 0, 1, 0, 8'h00);
        chk("t1 pop2", 32'(dout), 32'h22);
        step("t1 pop", 0, 1, 0, 8'h00);
        chk("t1 pop3", 32'(dout), 32'h11);
        chk("t1 empty", 32'(pusty), 32'd1);

        // 2: overflow
        for (int i = 0; i < 4; i++) step("t2 fill", 1, 0, 0, 8'hA0 + 8'(i));
        chk("t2 pelny", 32'(pelny), 32'd1);
        step("t2 ovf", 1, 0, 0, 8'hFF);
        chk("t2 przep", 32'(przepelnienie), 32'd1);
        chk("t2 cnt4", 32'(licznik), 32'd4);
        step("t2 pop", 0, 1, 0, 8'h00);
        chk("t2 topA3", 32'(dout), 32'hA3);
        step("t2 clr", 0, 0, 1, 8'h00);
        chk("t2 cleared", 32'(przepelnienie), 32'd0);
        for (int i = 0; i < 3; i++) step("t2 drain", 0, 1, 0, 8'h00);

        // 3: underflow, error beats clear
        step("t3 unf", 0, 1, 0, 8'h00);
        chk("t3 nied", 32'(niedomiar), 32'd1);
        chk("t3 novalid", 32'(dout_valid), 32'd0);
        chk("t3 dout held", 32'(dout), 32'hA0);
        step("t3 clr+unf", 0, 1, 1, 8'h00);
        chk("t3 nied wins", 32'(niedomiar), 32'd1);

        // 5: asynchronous reset between edges
        step("t5 push", 1, 0, 0, 8'h01);
        step("t5 push", 1, 0, 0, 8'h02);
        step("t5 pop", 0, 1, 0, 8'h00);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5 cnt", 32'(licznik), 32'd0);
        chk("t5 dout", 32'(dout), 32'd0);
        chk("t5 valid", 32'(dout_valid), 32'd0);
        chk("t5 nied", 32'(niedomiar), 32'd0);
        chk("t5 przep", 32'(przepelnienie), 32'd0);
        model_reset();
        @(negedge clk) rst = 1'b0;
        step("t5 pop after rst", 0, 1, 0, 8'h00);
        chk("t5 unf", 32'(niedomiar), 32'd1);
        step("t5 clr", 0, 0, 1, 8'h00);

        // 4: swap
        step("t4 push", 1, 0, 0, 8'h55);
        step("t4 swap", 1, 1, 0, 8'h66);
        chk("t4 swap dout", 32'(dout), 32'h55);
        chk("t4 swap cnt", 32'(licznik), 32'd1);
        step("t4 pop", 0, 1, 0, 8'h00);
        chk("t4 pop dout", 32'(dout), 32'h66);
        step("t4 swap empty", 1, 1, 0, 8'h77);
        chk("t4 bypass", 32'(dout), 32'h77);
        chk("t4 bypass cnt", 32'(licznik), 32'd0);
        chk("t4 no flags", 32'({przepelnienie, niedomiar}), 32'd0);

        // 6: random traffic
        for (int i = 0; i < 1000; i++) begin
            r = int'($urandom_range(0, 3));
            step("t6", r[1], r[0], ($urandom_range(0, 7) == 0), 8'($urandom));
        end

        repeat (2) @(negedge clk);
        #1;
        chk("sb drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
